// File: rtl/color_detect_prod_accum_if.sv
// Stream bundle for color_detect_prod_accum: product input stream and result output stream.
// The slave modport is the accumulator's view; the master modport is the surrounding environment.
interface color_detect_prod_accum_if #(
  parameter int ACC_W  = 48,
  parameter int LEN_W  = 16,
  parameter int PROD_W = 32
);
  // Both streams use valid/ready: a beat transfers on a rising edge where valid && ready.
  // A producer holds valid and its payload stable until the transfer; ready never depends
  // combinationally on valid.
  logic              s_valid;
  logic              s_ready;
  logic [PROD_W-1:0] s_prod;
  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_sum;
  logic [LEN_W-1:0]  m_hits;

  modport slave (
    input  s_valid, s_prod, m_ready,
    output s_ready, m_valid, m_sum, m_hits
  );

  modport master (
    output s_valid, s_prod, m_ready,
    input  s_ready, m_valid, m_sum, m_hits
  );
endinterface

// File: rtl/color_detect_prod_accum.sv
// Accumulates a programmed number of products and counts those above a threshold.
// Optional macro COLOR_DETECT_ACC_SAT_EN: saturate the sum on carry-out instead of wrapping.
module color_detect_prod_accum #(
  parameter int ACC_W  = 48,
  parameter int LEN_W  = 16,
  parameter int PROD_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [PROD_W-1:0]  thresh,
  color_detect_prod_accum_if.slave bus,
  output logic               busy,
  output logic               ovf,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  hits_q, hits_d;
  logic [PROD_W-1:0] thresh_q, thresh_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic              beat;
  logic [ACC_W:0]    sum_ext;
  logic              carry;

  assign beat    = (state_q == ACC) && bus.s_valid;
  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(bus.s_prod);
  assign carry   = sum_ext[ACC_W];

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hits_d   = hits_q;
    thresh_d = thresh_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len;
          thresh_d = thresh;
          acc_d    = '0;
          hits_d   = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = (len == '0) ? OUT : ACC;
        end
      end
      ACC: begin
        if (beat) begin
`ifdef COLOR_DETECT_ACC_SAT_EN
          acc_d = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
          acc_d = sum_ext[ACC_W-1:0];
`endif
          ovf_d  = ovf_q | carry;
          hits_d = hits_q + LEN_W'(bus.s_prod > thresh_q);
          cnt_d  = cnt_q + 1'b1;
          // len_q is never zero here, so len_q - 1 cannot wrap.
          if (cnt_q == len_q - 1'b1) state_d = OUT;
        end
      end
      OUT: begin
        if (bus.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      hits_q   <= '0;
      thresh_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hits_q   <= hits_d;
      thresh_q <= thresh_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  // All outputs are decodes of registered state; m_ready only affects the next state.
  assign bus.s_ready = (state_q == ACC);
  assign bus.m_valid = (state_q == OUT);
  assign bus.m_sum   = acc_q;
  assign bus.m_hits  = hits_q;
  assign busy        = (state_q != IDLE);
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_color_detect_prod_accum.sv
// Directed bench for color_detect_prod_accum, built with a 33-bit accumulator so overflow is reachable.
module tb_color_detect_prod_accum;
  localparam int ACC_W  = 33;
  localparam int LEN_W  = 16;
  localparam int PROD_W = 32;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [PROD_W-1:0] thresh;
  logic              busy;
  logic              ovf;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] exp_sum;

  color_detect_prod_accum_if #(.ACC_W(ACC_W), .LEN_W(LEN_W), .PROD_W(PROD_W)) bus ();

  color_detect_prod_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W), .PROD_W(PROD_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .len         (len),
    .thresh      (thresh),
    .bus         (bus),
    .busy        (busy),
    .ovf         (ovf),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l, input logic [PROD_W-1:0] t);
    start  = 1'b1;
    len    = l;
    thresh = t;
    tick();
    start  = 1'b0;
  endtask

  task automatic send(input logic [PROD_W-1:0] p);
    int g = 0;
    bus.s_valid = 1'b1;
    bus.s_prod  = p;
    while (!bus.s_ready && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, g);
    end
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic accept();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if ({bus.s_ready, bus.m_valid, busy, ovf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: s_ready/m_valid/busy/ovf=%b, required 0000",
               {bus.s_ready, bus.m_valid, busy, ovf});
    end
    n_checks++;
    if (bus.m_sum !== '0 || bus.m_hits !== '0) begin
      n_fail++;
      $display("FAIL reset_data: sum=%h hits=%0d, required 0/0", bus.m_sum, bus.m_hits);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d, required 0", dbg_state);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [PROD_W-1:0] prods [4];
    prods[0] = 32'd50; prods[1] = 32'd100; prods[2] = 32'd101; prods[3] = 32'hFFFF_FFFF;
    exp_q.push_back(33'h1_0000_00FA);
    do_start(16'd4, 32'd100);
    n_checks++;
    if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_enter_acc: busy=%b s_ready=%b, required 1/1", busy, bus.s_ready);
    end
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_prod = prods[i];
      tick();
    end
    bus.s_valid = 1'b0;
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: m_valid=%b s_ready=%b, required 1/0", bus.m_valid, bus.s_ready);
    end
    exp_sum = exp_q.pop_front();
    n_checks++;
    if (bus.m_sum !== exp_sum) begin
      n_fail++;
      $display("FAIL basic_sum: got %h, required %h", bus.m_sum, exp_sum);
    end
    n_checks++;
    if (bus.m_hits !== 16'd2 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hits: hits=%0d ovf=%b, required 2/0", bus.m_hits, ovf);
    end
    accept();
    n_checks++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: m_valid=%b busy=%b, required 0/0", bus.m_valid, busy);
    end
  endtask

  task automatic test_len_zero();
    logic sr_seen;
    bus.s_valid = 1'b1;
    bus.s_prod  = 32'd9;
    do_start(16'd0, 32'd0);
    sr_seen = bus.s_ready;
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_sum !== '0 || bus.m_hits !== '0) begin
      n_fail++;
      $display("FAIL len0_result: m_valid=%b sum=%h hits=%0d, required 1/0/0",
               bus.m_valid, bus.m_sum, bus.m_hits);
    end
    tick();
    sr_seen = sr_seen | bus.s_ready;
    accept();
    sr_seen = sr_seen | bus.s_ready;
    bus.s_valid = 1'b0;
    n_checks++;
    if (sr_seen !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_no_ready: s_ready seen=%b busy=%b, required 0/0", sr_seen, busy);
    end
  endtask

  task automatic test_stall();
    exp_q.push_back(33'd60);
    do_start(16'd3, 32'd15);
    bus.s_valid = 1'b0;
    tick();
    send(32'd10);
    tick();
    tick();
    send(32'd20);
    send(32'd30);
    exp_sum = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      start  = (c == 2);
      len    = 16'd7;
      thresh = 32'd0;
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_sum !== exp_sum || bus.m_hits !== 16'd2) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: m_valid=%b sum=%h hits=%0d, required 1/%h/2",
                 c, bus.m_valid, bus.m_sum, bus.m_hits, exp_sum);
      end
      tick();
    end
    start = 1'b0;
    accept();
    tick();
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_start_ignored: busy=%b state=%0d, required 0/0", busy, dbg_state);
    end
  endtask

  task automatic test_overflow();
`ifdef COLOR_DETECT_ACC_SAT_EN
    exp_q.push_back(33'h1_FFFF_FFFF);
`else
    exp_q.push_back(33'h0_FFFF_FFFD);
`endif
    do_start(16'd3, 32'hFFFF_FFFF);
    bus.s_valid = 1'b1;
    bus.s_prod  = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) tick();
    bus.s_valid = 1'b0;
    exp_sum = exp_q.pop_front();
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_sum !== exp_sum) begin
      n_fail++;
      $display("FAIL ovf_sum: m_valid=%b sum=%h, required 1/%h", bus.m_valid, bus.m_sum, exp_sum);
    end
    n_checks++;
    if (ovf !== 1'b1 || bus.m_hits !== '0) begin
      n_fail++;
      $display("FAIL ovf_flag: ovf=%b hits=%0d, required 1/0", ovf, bus.m_hits);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    do_start(16'd5, 32'd0);
    bus.s_valid = 1'b1;
    bus.s_prod  = 32'd3;
    tick();
    tick();
    bus.s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.s_ready, bus.m_valid, busy, ovf} !== 4'b0000 || bus.m_sum !== '0 || bus.m_hits !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: flags=%b sum=%h hits=%0d, required 0000/0/0",
               {bus.s_ready, bus.m_valid, busy, ovf}, bus.m_sum, bus.m_hits);
    end
    tick();
    reset_n = 1'b1;
    tick();
    exp_q.push_back(33'd7);
    do_start(16'd1, 32'd0);
    send(32'd7);
    exp_sum = exp_q.pop_front();
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_sum !== exp_sum || bus.m_hits !== 16'd1) begin
      n_fail++;
      $display("FAIL midreset_restart: m_valid=%b sum=%h hits=%0d, required 1/%h/1",
               bus.m_valid, bus.m_sum, bus.m_hits, exp_sum);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    do_start(16'd2, 32'd0);
    bus.s_valid = 1'b1;
    bus.s_prod  = 32'd1;
    tick();
    bus.s_prod  = 32'd2;
    tick();
    bus.s_valid = 1'b0;
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_sum !== 33'd3) begin
      n_fail++;
      $display("FAIL b2b_first: m_valid=%b sum=%h, required 1/3", bus.m_valid, bus.m_sum);
    end
    bus.m_ready = 1'b1;
    start       = 1'b1;
    len         = 16'd0;
    tick();
    bus.m_ready = 1'b0;
    start       = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start_in_out: busy=%b m_valid=%b, required 0/0", busy, bus.m_valid);
    end
    do_start(16'd0, 32'd0);
    n_checks++;
    if (busy !== 1'b1 || bus.m_valid !== 1'b1 || bus.m_sum !== '0) begin
      n_fail++;
      $display("FAIL b2b_next_start: busy=%b m_valid=%b sum=%h, required 1/1/0",
               busy, bus.m_valid, bus.m_sum);
    end
    accept();
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    len         = '0;
    thresh      = '0;
    bus.s_valid = 1'b0;
    bus.s_prod  = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_len_zero();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
